// File: rtl/pll_startup_ctrl.sv
// Power-up, bias auto-trim and lock supervision for the 8x PLL, clocked by the PLL reference.
// Build option PLL_TRIM_OVERRIDE_EN adds a fixed trim-code override sampled while OFF.
module pll_startup_ctrl #(
   parameter int         BIAS_CYC   = 64,
   parameter int         SETTLE_CYC = 512,
   parameter int         WINDOW     = 256,
   parameter int         TARGET     = 32,
   parameter int         TOL        = 1,
   parameter logic [3:0] TRIM_INIT  = 4'd8,
   parameter int         MAX_RETRY  = 16,
   parameter int         LOSS_CNT   = 2
) (
   input  logic       i_clk,
   input  logic       i_resetn,
   input  logic       i_enable,
   input  logic       i_pll_div,
`ifdef PLL_TRIM_OVERRIDE_EN
   input  logic       i_trim_ovr,
   input  logic [3:0] i_trim_ovr_val,
`endif
   output logic       o_en_cp,
   output logic       o_en_vco,
   output logic [3:0] o_trim,
   output logic       o_clk_sel,
   output logic       o_locked,
   output logic       o_fail,
   output logic [2:0] o_state,
   output logic [8:0] o_meas_cnt
);

   // state  | meaning
   // OFF    | everything disabled, trim reloaded, waiting for enable
   // BIAS   | charge pump up, bias settling
   // VCO    | VCO running, settling after start or trim change
   // MEAS   | one frequency window being counted
   // TRIM   | single-cycle bias code step
   // LOCKED | core clock on PLL, windows checked back-to-back
   // FAIL   | trim range or retries exhausted, held until enable drops
   typedef enum logic [2:0] {
      S_OFF    = 3'd0,
      S_BIAS   = 3'd1,
      S_VCO    = 3'd2,
      S_MEAS   = 3'd3,
      S_TRIM   = 3'd4,
      S_LOCKED = 3'd5,
      S_FAIL   = 3'd6
   } state_t;

   localparam logic [9:0] BIAS_LD   = 10'(BIAS_CYC - 1);
   localparam logic [9:0] SETTLE_LD = 10'(SETTLE_CYC - 1);
   localparam logic [9:0] WIN_LD    = 10'(WINDOW - 1);
   localparam logic [8:0] CNT_LO    = 9'(TARGET - TOL);
   localparam logic [8:0] CNT_HI    = 9'(TARGET + TOL);
   localparam logic [4:0] RETRY_MAX = 5'(MAX_RETRY);
   localparam logic [1:0] LOSS_LAST = 2'(LOSS_CNT - 1);

   state_t     r_state, w_state_nx;
   logic [9:0] r_timer, w_timer_nx;
   logic [8:0] r_win, w_win_nx, w_win_end;
   logic [8:0] r_meas, w_meas_nx;
   logic [3:0] r_trim, w_trim_nx, w_trim_load;
   logic [4:0] r_retry, w_retry_nx;
   logic [1:0] r_bad, w_bad_nx;
   logic       r_dir_up, w_dir_up_nx;
   logic [2:0] r_div_sync;
   logic       w_div_rise, w_tc, w_low, w_high, w_good, w_step_blk;
   logic       w_ovr;
   logic [3:0] w_ovr_code;
   logic       r_en_cp, r_en_vco, r_clk_sel, r_locked, r_fail;

   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) r_div_sync <= '0;
      else           r_div_sync <= {r_div_sync[1:0], i_pll_div};
   end

   assign w_div_rise = r_div_sync[1] & ~r_div_sync[2];

`ifdef PLL_TRIM_OVERRIDE_EN
   logic       r_ovr;
   logic [3:0] r_ovr_val;

   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_ovr     <= 1'b0;
         r_ovr_val <= '0;
      end else if (r_state == S_OFF) begin
         r_ovr     <= i_trim_ovr;
         r_ovr_val <= i_trim_ovr_val;
      end
   end

   // Live inputs while OFF so the code is already in place on the way out of OFF.
   assign w_ovr      = (r_state == S_OFF) ? i_trim_ovr     : r_ovr;
   assign w_ovr_code = (r_state == S_OFF) ? i_trim_ovr_val : r_ovr_val;
`else
   assign w_ovr      = 1'b0;
   assign w_ovr_code = TRIM_INIT;
`endif

   assign w_trim_load = w_ovr ? w_ovr_code : TRIM_INIT;
   assign w_tc        = (r_timer == '0);
   // An edge seen on the last window cycle belongs to the ending window.
   assign w_win_end   = (w_div_rise && (r_win != 9'd511)) ? r_win + 9'd1 : r_win;
   assign w_low       = (w_win_end < CNT_LO);
   assign w_high      = (w_win_end > CNT_HI);
   assign w_good      = !w_low && !w_high;
   assign w_step_blk  = w_ovr ? 1'b0 :
                        ((r_dir_up ? (r_trim == 4'd15) : (r_trim == 4'd0)) || (r_retry == RETRY_MAX));

   always_comb begin
      w_state_nx  = r_state;
      w_timer_nx  = w_tc ? r_timer : r_timer - 10'd1;
      w_win_nx    = w_win_end;
      w_meas_nx   = r_meas;
      w_trim_nx   = r_trim;
      w_retry_nx  = r_retry;
      w_bad_nx    = r_bad;
      w_dir_up_nx = r_dir_up;
      if (!i_enable) begin
         w_state_nx = S_OFF;
         w_timer_nx = '0;
         w_win_nx   = '0;
         w_meas_nx  = '0;
         w_trim_nx  = w_trim_load;
         w_retry_nx = '0;
         w_bad_nx   = '0;
      end else begin
         case (r_state)
            S_OFF: begin
               w_state_nx = S_BIAS;
               w_timer_nx = BIAS_LD;
               w_trim_nx  = w_trim_load;
               w_retry_nx = '0;
            end
            S_BIAS: if (w_tc) begin
               w_state_nx = S_VCO;
               w_timer_nx = SETTLE_LD;
            end
            S_VCO: if (w_tc) begin
               w_state_nx = S_MEAS;
               w_timer_nx = WIN_LD;
               w_win_nx   = '0;
            end
            S_MEAS: if (w_tc) begin
               w_meas_nx   = w_win_end;
               w_win_nx    = '0;
               w_dir_up_nx = w_low;
               if (w_good) begin
                  w_state_nx = S_LOCKED;
                  w_timer_nx = WIN_LD;
                  w_bad_nx   = '0;
               end else if (w_ovr) begin
                  w_state_nx = S_FAIL;
               end else begin
                  w_state_nx = S_TRIM;
               end
            end
            S_TRIM: begin
               if (w_step_blk) begin
                  w_state_nx = S_FAIL;
               end else begin
                  w_state_nx = S_VCO;
                  w_timer_nx = SETTLE_LD;
                  if (!w_ovr) begin
                     w_retry_nx = r_retry + 5'd1;
                     w_trim_nx  = r_dir_up ? r_trim + 4'd1 : r_trim - 4'd1;
                  end
               end
            end
            S_LOCKED: if (w_tc) begin
               w_meas_nx  = w_win_end;
               w_win_nx   = '0;
               w_timer_nx = WIN_LD;
               if (w_good) begin
                  w_bad_nx = '0;
               end else if (r_bad == LOSS_LAST) begin
                  w_state_nx  = S_TRIM;
                  w_dir_up_nx = w_low;
                  w_bad_nx    = '0;
               end else begin
                  w_bad_nx = r_bad + 2'd1;
               end
            end
            S_FAIL: w_state_nx = S_FAIL;
            default: w_state_nx = S_OFF;
         endcase
      end
   end

   // Outputs are decoded from the next state so they are registered yet change with the state.
   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_state   <= S_OFF;
         r_timer   <= '0;
         r_win     <= '0;
         r_meas    <= '0;
         r_trim    <= TRIM_INIT;
         r_retry   <= '0;
         r_bad     <= '0;
         r_dir_up  <= 1'b0;
         r_en_cp   <= 1'b0;
         r_en_vco  <= 1'b0;
         r_clk_sel <= 1'b0;
         r_locked  <= 1'b0;
         r_fail    <= 1'b0;
      end else begin
         r_state   <= w_state_nx;
         r_timer   <= w_timer_nx;
         r_win     <= w_win_nx;
         r_meas    <= w_meas_nx;
         r_trim    <= w_trim_nx;
         r_retry   <= w_retry_nx;
         r_bad     <= w_bad_nx;
         r_dir_up  <= w_dir_up_nx;
         r_en_cp   <= (w_state_nx == S_BIAS) || (w_state_nx == S_VCO) || (w_state_nx == S_MEAS) ||
                      (w_state_nx == S_TRIM) || (w_state_nx == S_LOCKED);
         r_en_vco  <= (w_state_nx == S_VCO) || (w_state_nx == S_MEAS) ||
                      (w_state_nx == S_TRIM) || (w_state_nx == S_LOCKED);
         r_clk_sel <= (w_state_nx == S_LOCKED);
         r_locked  <= (w_state_nx == S_LOCKED);
         r_fail    <= (w_state_nx == S_FAIL);
      end
   end

   assign o_en_cp    = r_en_cp;
   assign o_en_vco   = r_en_vco;
   assign o_trim     = r_trim;
   assign o_clk_sel  = r_clk_sel;
   assign o_locked   = r_locked;
   assign o_fail     = r_fail;
   assign o_state    = r_state;
   assign o_meas_cnt = r_meas;

endmodule
